telemetry_tx_scheduler: RTL and testbench

//  Owns the single 8-bit UART transmitter and decides what it sends, byte by byte.
//  - Periodically snapshots the pong game state and sends it as a 10-byte telemetry frame.
//  - Arbitrates the UART between that frame stream and a 2-byte event channel (score/debug events).
//  - Sits between the game core (paddles, ball, scores) and the Uart8 instance.

---
 rtl/telemetry_tx_scheduler.sv | 159 +++++++++++++++
 tb/tb_telemetry_tx_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_tx_scheduler.sv
// Schedules the single UART transmitter. It sends periodic 10-byte game-state frames,
// which take priority over 2-byte event messages. Messages are never interleaved.
module telemetry_tx_scheduler #(
    parameter int unsigned FRAME_PERIOD = 200_000,
    parameter logic [7:0]  HDR_BYTE     = 8'hAA,
    parameter logic [7:0]  FTR_BYTE     = 8'h55,
    parameter logic [7:0]  EVT_BYTE     = 8'hE5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] score_left,
    input  logic [3:0] score_right,
    input  logic [3:0] pos_left,
    input  logic [3:0] pos_right,
    input  logic [5:0] ball_x,
    input  logic [5:0] ball_y,
    input  logic [3:0] ball_radius,
    input  logic       evt_valid,
    input  logic [7:0] evt_data,
    output logic       evt_ready,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       frame_sent,
    output logic [7:0] overrun_cnt
);
    localparam int unsigned CNT_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] period_cnt;
    logic             tick;
    logic             frame_pend;
    logic             src_frame;
    logic [3:0]       idx;
    logic [3:0]       idx_nxt;
    logic             last_byte;
    logic [7:0]       evt_latch;
    logic [7:0]       chk;
    logic [7:0]       nxt_frame_byte;
    logic [3:0]       snap_sl, snap_sr, snap_pl, snap_pr, snap_br;
    logic [5:0]       snap_bx, snap_by;

    assign tick = (period_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       period_cnt <= '0;
        else if (tick) period_cnt <= '0;
        else           period_cnt <= period_cnt + 1'b1;
    end

    // The snapshot is only written on an accepted tick, so an in-flight frame stays coherent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_sl <= '0;
            snap_sr <= '0;
            snap_pl <= '0;
            snap_pr <= '0;
            snap_bx <= '0;
            snap_by <= '0;
            snap_br <= '0;
        end else if (tick && !frame_pend) begin
            snap_sl <= score_left;
            snap_sr <= score_right;
            snap_pl <= pos_left;
            snap_pr <= pos_right;
            snap_bx <= ball_x;
            snap_by <= ball_y;
            snap_br <= ball_radius;
        end
    end

    always_comb begin
        chk = {4'h0, snap_sl} ^ {4'h0, snap_sr} ^ {4'h0, snap_pl} ^ {4'h0, snap_pr}
            ^ {2'b00, snap_bx} ^ {2'b00, snap_by} ^ {4'h0, snap_br};
        idx_nxt        = idx + 4'd1;
        last_byte      = src_frame ? (idx == 4'd9) : (idx == 4'd1);
        nxt_frame_byte = FTR_BYTE;
        case (idx_nxt)
            4'd1:    nxt_frame_byte = {4'h0, snap_sl};
            4'd2:    nxt_frame_byte = {4'h0, snap_sr};
            4'd3:    nxt_frame_byte = {4'h0, snap_pl};
            4'd4:    nxt_frame_byte = {4'h0, snap_pr};
            4'd5:    nxt_frame_byte = {2'b00, snap_bx};
            4'd6:    nxt_frame_byte = {2'b00, snap_by};
            4'd7:    nxt_frame_byte = {4'h0, snap_br};
            4'd8:    nxt_frame_byte = chk;
            default: nxt_frame_byte = FTR_BYTE;
        endcase
    end

    // tx_start/tx_data are loaded on entry to START, so the pulse coincides with the START cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            frame_pend  <= 1'b0;
            src_frame   <= 1'b0;
            idx         <= '0;
            evt_latch   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            evt_ready   <= 1'b0;
            frame_sent  <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            tx_start   <= 1'b0;
            evt_ready  <= 1'b0;
            frame_sent <= 1'b0;

            if (tick) begin
                if (!frame_pend)              frame_pend  <= 1'b1;
                else if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (frame_pend) begin
                        src_frame <= 1'b1;
                        idx       <= '0;
                        tx_data   <= HDR_BYTE;
                        tx_start  <= 1'b1;
                        state     <= START;
                    end else if (!tick && evt_valid) begin
                        evt_ready <= 1'b1;
                        evt_latch <= evt_data;
                        src_frame <= 1'b0;
                        idx       <= '0;
                        tx_data   <= EVT_BYTE;
                        tx_start  <= 1'b1;
                        state     <= START;
                    end
                end
                START: state <= WAIT_ACK;
                WAIT_ACK: begin
                    if (tx_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_byte) begin
                            state <= IDLE;
                            if (src_frame) begin
                                frame_pend <= 1'b0;
                                frame_sent <= 1'b1;
                            end
                        end else begin
                            idx      <= idx_nxt;
                            tx_data  <= src_frame ? nxt_frame_byte : evt_latch;
                            tx_start <= 1'b1;
                            state    <= START;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_telemetry_tx_scheduler.sv
// Bench for telemetry_tx_scheduler. One instance (period 2000) runs directed scenarios and
// one (period 50) runs random traffic. Both are scored against a frame/event stream model.
module tb_telemetry_tx_scheduler;
    localparam int P0 = 2000;
    localparam int P1 = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst         [2];
    logic [3:0] score_left  [2];
    logic [3:0] score_right [2];
    logic [3:0] pos_left    [2];
    logic [3:0] pos_right   [2];
    logic [5:0] ball_x      [2];
    logic [5:0] ball_y      [2];
    logic [3:0] ball_radius [2];
    logic       evt_valid   [2];
    logic [7:0] evt_data    [2];
    logic       evt_ready   [2];
    logic       tx_busy     [2];
    logic       tx_start    [2];
    logic [7:0] tx_data     [2];
    logic       frame_sent  [2];
    logic [7:0] overrun_cnt [2];

    int checks = 0;
    int errors = 0;
    int sent_cnt [2] = '{0, 0};
    int cyc0 = 0;
    logic done0 = 1'b0;
    logic done1 = 1'b0;
    logic [7:0] rxlog0 [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame built directly from the field values.
    function automatic logic [79:0] build(input logic [3:0] sl, input logic [3:0] sr,
                                          input logic [3:0] pl, input logic [3:0] pr,
                                          input logic [5:0] bx, input logic [5:0] by,
                                          input logic [3:0] br);
        logic [7:0] b [7];
        logic [7:0] c;
        b = '{{4'h0, sl}, {4'h0, sr}, {4'h0, pl}, {4'h0, pr}, {2'b00, bx}, {2'b00, by}, {4'h0, br}};
        c = 8'h00;
        for (int i = 0; i < 7; i++) c = c ^ b[i];
        return {8'hAA, b[0], b[1], b[2], b[3], b[4], b[5], b[6], c, 8'h55};
    endfunction

    always @(posedge clk) cyc0 <= rst[0] ? 0 : cyc0 + 1;

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int P = (g == 0) ? P0 : P1;

        telemetry_tx_scheduler #(.FRAME_PERIOD(P)) dut (
            .clk(clk), .rst(rst[g]),
            .score_left(score_left[g]), .score_right(score_right[g]),
            .pos_left(pos_left[g]), .pos_right(pos_right[g]),
            .ball_x(ball_x[g]), .ball_y(ball_y[g]), .ball_radius(ball_radius[g]),
            .evt_valid(evt_valid[g]), .evt_data(evt_data[g]), .evt_ready(evt_ready[g]),
            .tx_busy(tx_busy[g]), .tx_start(tx_start[g]), .tx_data(tx_data[g]),
            .frame_sent(frame_sent[g]), .overrun_cnt(overrun_cnt[g])
        );

        logic [79:0] fq [$];
        logic [7:0]  eq [$];
        logic [79:0] cur = '0;
        logic [7:0]  held = '0;
        int   pidx = 0, done_pend = 0, busy_left = 0, mcnt = 0, movr = 0;
        logic mpend = 1'b0, is_frame = 1'b0, prev_ok = 1'b0, aborted = 1'b0;

        initial tx_busy[g] = 1'b0;

        task automatic take_byte(input logic [7:0] b);
            logic [7:0] e;
            if (g == 0) rxlog0.push_back(b);
            if (pidx == 0) begin
                is_frame = (b == 8'hAA);
                if (is_frame) begin
                    check_val("frame_queued", fq.size() > 0, 1);
                    cur = (fq.size() > 0) ? fq.pop_front() : '0;
                end
            end
            if (is_frame)       e = cur[79 - 8 * pidx -: 8];
            else if (pidx == 0) e = 8'hE5;
            else begin
                check_val("event_queued", eq.size() > 0, 1);
                e = (eq.size() > 0) ? eq.pop_front() : ~b;
            end
            check_val((g == 0) ? "byte_p2000" : "byte_p50", b, e);
            pidx++;
            if (pidx == (is_frame ? 10 : 2)) begin
                pidx = 0;
                if (is_frame) done_pend++;
            end
        endtask

        always @(negedge clk) begin
            // UART: busy one cycle after tx_start for 20 cycles; unaffected by scheduler reset.
            if (busy_left > 0) begin
                check_val("tx_start_while_busy", tx_start[g], 0);
                if (rst[g]) aborted = 1'b1;
                if (!aborted) check_val("tx_data_stable", tx_data[g], held);
                busy_left--;
                if (busy_left == 0) tx_busy[g] = 1'b0;
            end else if (tx_start[g]) begin
                held       = tx_data[g];
                aborted    = 1'b0;
                busy_left  = 20;
                tx_busy[g] = 1'b1;
                take_byte(tx_data[g]);
            end

            if (rst[g]) begin
                mcnt = 0; mpend = 1'b0; movr = 0; pidx = 0; done_pend = 0; prev_ok = 1'b0;
                fq.delete();
                eq.delete();
            end else begin
                mcnt = (mcnt + 1) % P;
                if (frame_sent[g]) begin
                    check_val("frame_sent_after_footer", done_pend, 1);
                    if (done_pend > 0) done_pend--;
                    check_val("overrun_cnt", overrun_cnt[g], movr);
                    mpend = 1'b0;
                    sent_cnt[g]++;
                end
                if (evt_ready[g]) begin
                    check_val("evt_ready_priority", prev_ok, 1);
                    eq.push_back(evt_data[g]);
                end
                prev_ok = !mpend && (mcnt != P - 1);
                if (mcnt == P - 1) begin
                    if (mpend) begin
                        if (movr < 255) movr++;
                    end else begin
                        mpend = 1'b1;
                        fq.push_back(build(score_left[g], score_right[g], pos_left[g], pos_right[g],
                                           ball_x[g], ball_y[g], ball_radius[g]));
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input int g);
        check_val("rst_tx_start", tx_start[g], 0);
        check_val("rst_tx_data", tx_data[g], 0);
        check_val("rst_evt_ready", evt_ready[g], 0);
        check_val("rst_frame_sent", frame_sent[g], 0);
        check_val("rst_overrun", overrun_cnt[g], 0);
    endtask

    task automatic wait_start(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start[0] && n < budget);
        check_val(tag, tx_start[0], 1);
    endtask

    task automatic wait_evt_ready(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!evt_ready[0] && n < budget);
        check_val("evt_ready_seen", evt_ready[0], 1);
    endtask

    logic [7:0] exp_log [24] = '{8'hAA, 8'h03, 8'h05, 8'h02, 8'h09, 8'h21, 8'h11, 8'h02, 8'h3F, 8'h55,
                                 8'hE5, 8'h3C,
                                 8'hAA, 8'h03, 8'h05, 8'h02, 8'h09, 8'h28, 8'h11, 8'h02, 8'h36, 8'h55,
                                 8'hE5, 8'h7E};

    initial begin : directed
        int n;
        int mark;
        rst[0] = 1'b1; evt_valid[0] = 1'b0; evt_data[0] = 8'h00;
        score_left[0] = 4'd3; score_right[0] = 4'd5; pos_left[0] = 4'd2; pos_right[0] = 4'd9;
        ball_x[0] = 6'd33; ball_y[0] = 6'd17; ball_radius[0] = 4'd2;
        repeat (3) @(negedge clk);
        check_reset_outputs(0);
        #2 rst[0] = 1'b0;

        wait_start(P0 + 100, "first_start_seen");
        check_val("tick_to_start_latency", cyc0, P0 + 1);
        repeat (2) wait_start(100, "byte_start_seen");
        @(posedge clk); #1 ball_x[0] = 6'd40;
        wait_start(100, "byte_start_seen");
        @(posedge clk); #1 begin evt_valid[0] = 1'b1; evt_data[0] = 8'h3C; end
        wait_evt_ready(1000);
        check_val("evt_after_frame_sent", sent_cnt[0], 1);
        @(posedge clk); #1 evt_valid[0] = 1'b0;

        while (cyc0 < P0 * 2 - 2) @(negedge clk);
        @(posedge clk); #1 begin evt_valid[0] = 1'b1; evt_data[0] = 8'h7E; end
        wait_evt_ready(1000);
        check_val("tick_and_evt_frame_first", sent_cnt[0], 2);
        @(posedge clk); #1 evt_valid[0] = 1'b0;
        n = 0;
        while (rxlog0.size() < 24 && n < 1000) begin @(negedge clk); n++; end
        check_val("log_length", rxlog0.size() >= 24, 1);
        for (int i = 0; i < 24; i++)
            check_val("log_byte", (rxlog0.size() > i) ? rxlog0[i] : 8'hxx, exp_log[i]);

        wait_start(P0 + 100, "third_frame_start");
        repeat (3) wait_start(100, "byte_start_seen");
        repeat (5) @(negedge clk);
        #2 rst[0] = 1'b1;
        @(negedge clk);
        check_reset_outputs(0);
        #2 rst[0] = 1'b0;
        mark = rxlog0.size();
        wait_start(P0 + 100, "post_reset_start");
        check_val("post_reset_latency", cyc0, P0 + 1);
        #1;
        check_val("post_reset_header", (rxlog0.size() > mark) ? rxlog0[mark] : 8'hxx, 8'hAA);
        n = 0;
        while (sent_cnt[0] < 3 && n < 400) begin @(negedge clk); n++; end
        check_val("post_reset_frame_sent", sent_cnt[0], 3);
        check_val("no_overrun_slow_period", overrun_cnt[0], 0);
        done0 = 1'b1;
    end

    task automatic randomize_inputs();
        score_left[1]  = 4'($urandom);
        score_right[1] = 4'($urandom);
        pos_left[1]    = 4'($urandom);
        pos_right[1]   = 4'($urandom);
        ball_x[1]      = 6'($urandom);
        ball_y[1]      = 6'($urandom);
        ball_radius[1] = 4'($urandom);
    endtask

    initial begin : random_traffic
        rst[1] = 1'b1; evt_valid[1] = 1'b0; evt_data[1] = 8'h00;
        randomize_inputs();
        repeat (3) @(negedge clk);
        check_reset_outputs(1);
        #2 rst[1] = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0) randomize_inputs();
            if (evt_ready[1]) evt_valid[1] = 1'b0;
            else if (!evt_valid[1] && $urandom_range(0, 99) == 0) begin
                evt_valid[1] = 1'b1;
                evt_data[1]  = 8'($urandom);
            end
        end
        done1 = 1'b1;
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

    initial begin : summary
        wait (done0 && done1);
        repeat (2) @(negedge clk);
        check_val("overrun_saturated", overrun_cnt[1], 255);
        check_val("fast_period_frames", sent_cnt[1] > 40, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
